eth_arp_ctrl: RTL

- Sequences the ARP transmit engine in the ARP test design.
- Decides when the engine sends an ARP request and when it sends an ARP reply, and supplies the destination fields for each frame.
- Issues a request to TARGET_IP on a debounced touch_key press, retries on timeout, and answers incoming ARP requests.
- Exposes the resolved peer MAC to the rest of the design. Sits in the gmii_rx_clk domain, between the ARP receive and transmit modules.

---
 rtl/eth_arp_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/eth_arp_ctrl.sv
// eth_arp_ctrl: sequences ARP requests/replies for the ARP transmit engine.
// Debounces touch_key, resolves TARGET_IP with timed retries and answers incoming requests.
module eth_arp_ctrl #(
    parameter int unsigned DEB_CYCLES     = 2_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [31:0] TARGET_IP      = 32'hC0A8_0066,
    parameter logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        touch_key,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic [47:0] res_mac,
    output logic        res_valid,
    output logic        arp_fail
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DW-1:0] DEB_FULL = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RET_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, SEND_REQ, WAIT_REQ_TX, WAIT_REPLY, SEND_RPY, WAIT_RPY_TX} state_t;

    state_t          state_q, state_d, ret_q, ret_d;
    logic            key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic            pend_req_q, pend_req_d, pend_rpy_q, pend_rpy_d;
    logic [47:0]     rpy_mac_q, rpy_mac_d, des_mac_q, des_mac_d, res_mac_q, res_mac_d;
    logic [31:0]     rpy_ip_q, rpy_ip_d, des_ip_q, des_ip_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            tx_type_q, tx_type_d, res_valid_q, res_valid_d, arp_fail_q, arp_fail_d;
    logic            key_chg, key_evt, rx_req, rx_match, ld_req, ld_rpy;

    always_comb begin
        key_s1_d    = touch_key;
        key_s2_d    = key_s1_q;
        key_prev_d  = key_s2_q;
        key_chg     = key_s2_q != key_prev_q;
        // counter holds the number of consecutive cycles at the current level, saturating
        deb_cnt_d   = key_chg ? DW'(1) : (deb_cnt_q == DEB_FULL ? deb_cnt_q : deb_cnt_q + 1'b1);
        key_evt     = key_s2_q && !key_chg && deb_cnt_q == DEB_LAST;
        rx_req      = arp_rx_done && !arp_rx_type;
        rx_match    = arp_rx_done && arp_rx_type && src_ip == TARGET_IP;
        state_d     = state_q;
        ret_d       = ret_q;
        pend_req_d  = pend_req_q | key_evt;
        pend_rpy_d  = pend_rpy_q;
        rpy_mac_d   = rpy_mac_q;
        rpy_ip_d    = rpy_ip_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        tx_type_d   = tx_type_q;
        des_mac_d   = des_mac_q;
        des_ip_d    = des_ip_q;
        res_mac_d   = rx_match ? src_mac : res_mac_q;
        res_valid_d = res_valid_q | rx_match;
        arp_fail_d  = arp_fail_q;
        ld_req      = 1'b0;
        ld_rpy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_rpy_q) begin
                    ld_rpy = 1'b1;
                    ret_d  = IDLE;
                end else if (key_evt || pend_req_q) begin
                    ld_req     = 1'b1;
                    pend_req_d = 1'b0;
                    retry_d    = '0;
                    arp_fail_d = 1'b0;
                end
            end
            SEND_REQ:    state_d = WAIT_REQ_TX;
            WAIT_REQ_TX: begin
                if (tx_done) begin
                    tmo_d   = '0;
                    state_d = WAIT_REPLY;
                end
            end
            WAIT_REPLY: begin
                tmo_d = tmo_q + 1'b1;
                if (rx_match) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST && retry_q != RET_MAX) begin
                    retry_d = retry_q + 1'b1;
                    ld_req  = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    arp_fail_d = 1'b1;
                    state_d    = IDLE;
                end else if (pend_rpy_q) begin
                    ld_rpy = 1'b1;
                    ret_d  = WAIT_REPLY;
                end
            end
            SEND_RPY: begin
                pend_rpy_d = 1'b0;
                state_d    = WAIT_RPY_TX;
            end
            WAIT_RPY_TX: state_d = tx_done ? ret_q : state_q;
            default:     state_d = IDLE;
        endcase
        // frame fields are captured on entry to SEND_* and held until the next one
        if (ld_req) begin
            state_d   = SEND_REQ;
            tx_type_d = 1'b0;
            des_mac_d = BCAST_MAC;
            des_ip_d  = TARGET_IP;
        end
        if (ld_rpy) begin
            state_d   = SEND_RPY;
            tx_type_d = 1'b1;
            des_mac_d = rpy_mac_q;
            des_ip_d  = rpy_ip_q;
        end
        if (rx_req) begin
            pend_rpy_d = 1'b1;
            rpy_mac_d  = src_mac;
            rpy_ip_d   = src_ip;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            key_s1_q    <= 1'b0;
            key_s2_q    <= 1'b0;
            key_prev_q  <= 1'b0;
            deb_cnt_q   <= '0;
            pend_req_q  <= 1'b0;
            pend_rpy_q  <= 1'b0;
            rpy_mac_q   <= '0;
            rpy_ip_q    <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            tx_type_q   <= 1'b0;
            des_mac_q   <= BCAST_MAC;
            des_ip_q    <= TARGET_IP;
            res_mac_q   <= '0;
            res_valid_q <= 1'b0;
            arp_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            key_prev_q  <= key_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            pend_req_q  <= pend_req_d;
            pend_rpy_q  <= pend_rpy_d;
            rpy_mac_q   <= rpy_mac_d;
            rpy_ip_q    <= rpy_ip_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            tx_type_q   <= tx_type_d;
            des_mac_q   <= des_mac_d;
            des_ip_q    <= des_ip_d;
            res_mac_q   <= res_mac_d;
            res_valid_q <= res_valid_d;
            arp_fail_q  <= arp_fail_d;
        end
    end

    assign arp_tx_en   = state_q == SEND_REQ || state_q == SEND_RPY;
    assign arp_tx_type = tx_type_q;
    assign des_mac     = des_mac_q;
    assign des_ip      = des_ip_q;
    assign res_mac     = res_mac_q;
    assign res_valid   = res_valid_q;
    assign arp_fail    = arp_fail_q;
endmodule
